// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and sizes for the 4-source round-robin mux arbiter.
// The state encoding and the source/select widths live here.
package mux4_rr_arbiter_pkg;

    localparam int NSRC = 4;
    localparam int SELW = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NSRC-1:0] onehot(
        input logic [SELW-1:0] idx
    );
        onehot = NSRC'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// structuralmux4: 4-bit wide, 4:1 mux built from two levels
// of gated 2:1 selection.
module structuralmux4 (
    input  logic [1:0] s,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [3:0] y
);

    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] m0;
    logic [3:0] m1;

    assign m0 = {4{s[0]}};
    assign m1 = {4{s[1]}};
    assign lo = (d0 & ~m0) | (d1 & m0);
    assign hi = (d2 & ~m0) | (d3 & m0);
    assign y  = (lo & ~m1) | (hi & m1);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of the shared 4:1 mux with bounded bursts
// and a registered valid-only output toward one consumer.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAXBURST = 4,
    parameter int CNTW     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       out_ready,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic [3:0] y,
    output logic       y_valid
);

    state_t            state;
    state_t            state_n;
    logic [NSRC-1:0]   gnt_n;
    logic [SELW-1:0]   s_n;
    logic [3:0]        y_n;
    logic              yv_n;
    logic [SELW-1:0]   ptr;
    logic [SELW-1:0]   ptr_n;
    logic [CNTW-1:0]   cnt;
    logic [CNTW-1:0]   cnt_n;
    logic [SELW-1:0]   pick;
    logic [3:0]        mux_y;
    logic              beat;
    logic              last;

    // First requester at or after ptr, wrapping mod NSRC.
    function automatic logic [SELW-1:0] rr_pick(
        input logic [NSRC-1:0] r,
        input logic [SELW-1:0] p
    );
        logic [SELW-1:0] idx;
        logic            found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            idx = p + SELW'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    structuralmux4 u_mux (
        .s  (s),
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .y  (mux_y)
    );

    assign pick = rr_pick(req, ptr);
    assign beat = (state == GRANT) && req[s] && out_ready;
    assign last = beat && (cnt == CNTW'(MAXBURST - 1));

    // Next-state: pick an owner in IDLE, move beats and release in GRANT.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        s_n     = s;
        y_n     = y;
        yv_n    = 1'b0;
        ptr_n   = ptr;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    gnt_n   = onehot(pick);
                    s_n     = pick;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (beat) begin
                    y_n   = mux_y;
                    yv_n  = 1'b1;
                    cnt_n = cnt + CNTW'(1);
                end
                if (!req[s] || last) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = s + SELW'(1);
                end
            end
        endcase
    end

    // State register; reset overrides any beat in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            s       <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            s       <= s_n;
            y       <= y_n;
            y_valid <= yv_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
        end
    end

endmodule
